// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction sequencer for a small register-file datapath.
// Fetches a 16-bit instruction, decodes it from the instruction register (IR) and
// drives the datapath control strobes for one (ALU: two) execute cycles.
// Optional build macro CTRL_STEP_EN adds a 'step' input that gates FETCH.
//
// Handshake-free control: every control output is a pure decode of the current
// FSM state and IR, so nothing in 'instr' reaches an output in the same cycle.
module control_fsm #(
    parameter int M = 3,   // register address width
    parameter int N = 8,   // datapath width
    parameter int P = 8    // program counter width
) (
    input  logic         clk,
    input  logic         rst,
`ifdef CTRL_STEP_EN
    input  logic         step,
`endif
    output logic [P-1:0] iaddr,
    input  logic [15:0]  instr,
    input  logic         z_flag,
    input  logic         n_flag,
    input  logic         o_flag,
    output logic [N-1:0] din,
    output logic [M-1:0] waddr,
    output logic [M-1:0] ra,
    output logic [M-1:0] rb,
    output logic [2:0]   op,
    output logic         ie,
    output logic         write,
    output logic         reada,
    output logic         readb,
    output logic         en,
    output logic         oe,
    output logic         halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Upper-nibble opcodes; any opcode with bit 3 clear is an ALU operation.
    localparam logic [3:0] OPC_LDI  = 4'b1000;
    localparam logic [3:0] OPC_OUT  = 4'b1001;
    localparam logic [3:0] OPC_BRZ  = 4'b1010;
    localparam logic [3:0] OPC_BRN  = 4'b1011;
    localparam logic [3:0] OPC_BRA  = 4'b1100;
    localparam logic [3:0] OPC_BRO  = 4'b1101;
    localparam logic [3:0] OPC_NOP  = 4'b1110;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    state_t        state;
    state_t        state_next;
    logic [P-1:0]  pc;
    logic [P-1:0]  pc_next;
    logic [15:0]   ir;
    logic          fetch_go;
    logic          branch_taken;

    // Instruction fields, always taken from the latched IR.
    logic [3:0]    ir_opc;
    logic [2:0]    ir_rd;
    logic [2:0]    ir_rs1;
    logic [2:0]    ir_rs2;
    logic [7:0]    ir_imm;
    logic [8:0]    ir_off;
    logic          ir_is_alu;
    logic [P-1:0]  pc_inc;
    logic [P-1:0]  pc_branch;

    assign ir_opc    = ir[15:12];
    assign ir_rd     = ir[11:9];
    assign ir_rs1    = ir[8:6];
    assign ir_rs2    = ir[5:3];
    assign ir_imm    = ir[7:0];
    assign ir_off    = ir[8:0];
    assign ir_is_alu = ~ir_opc[3];

    // Both sums wrap naturally modulo 2^P; the offset is sign-extended (or
    // truncated when P is narrower than the 9-bit field).
    assign pc_inc    = pc + P'(1);
    assign pc_branch = pc + P'($signed(ir_off));

    assign iaddr  = pc;
    assign halted = (state == HALT);

`ifdef CTRL_STEP_EN
    // Single-step mode: FETCH holds until the operator presses step.
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // State register; reset aborts any instruction in flight at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Program counter and instruction register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            pc <= pc_next;
            if (state == FETCH && fetch_go) begin
                ir <= instr;
            end
        end
    end

    // Branch condition, evaluated on the flags present during EXEC.
    always_comb begin
        branch_taken = 1'b0;
        case (ir_opc)
            OPC_BRZ: branch_taken = z_flag;
            OPC_BRN: branch_taken = n_flag;
            OPC_BRO: branch_taken = o_flag;
            OPC_BRA: branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (fetch_go) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (ir_is_alu) begin
                    state_next = WB;
                end else if (ir_opc == OPC_HALT) begin
                    state_next = HALT;
                end else begin
                    state_next = FETCH;
                end
            end
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Next program counter: single-cycle instructions retire in EXEC, ALU in WB.
    always_comb begin
        pc_next = pc;
        case (state)
            EXEC: begin
                case (ir_opc)
                    OPC_LDI, OPC_OUT, OPC_NOP: pc_next = pc_inc;
                    OPC_BRZ, OPC_BRN, OPC_BRO, OPC_BRA:
                        pc_next = branch_taken ? pc_branch : pc_inc;
                    default: pc_next = pc;   // ALU waits for WB, HALT freezes pc
                endcase
            end
            WB:      pc_next = pc_inc;
            default: pc_next = pc;
        endcase
    end

    // Datapath control decode from state and IR; everything idles by default.
    always_comb begin
        din   = '0;
        waddr = '0;
        ra    = '0;
        rb    = '0;
        op    = '0;
        ie    = 1'b0;
        write = 1'b0;
        reada = 1'b0;
        readb = 1'b0;
        en    = 1'b0;
        oe    = 1'b0;
        case (state)
            EXEC: begin
                if (ir_is_alu) begin
                    reada = 1'b1;
                    readb = 1'b1;
                    ra    = M'(ir_rs1);
                    rb    = M'(ir_rs2);
                    op    = ir_opc[2:0];
                    en    = 1'b1;
                end else if (ir_opc == OPC_LDI) begin
                    ie    = 1'b1;
                    write = 1'b1;
                    waddr = M'(ir_rd);
                    din   = N'(ir_imm);
                end else if (ir_opc == OPC_OUT) begin
                    reada = 1'b1;
                    ra    = M'(ir_rs1);
                    oe    = 1'b1;
                end
            end
            WB: begin
                // ALU result comes from the datapath, not the immediate path.
                write = 1'b1;
                waddr = M'(ir_rd);
                ie    = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed test of control_fsm with a small program in a
// combinational instruction memory. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_control_fsm;

    localparam int M = 3;
    localparam int N = 8;
    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
`ifdef CTRL_STEP_EN
    logic         step = 1'b1;
`endif
    logic [P-1:0] iaddr;
    logic [15:0]  instr;
    logic         z_flag = 1'b0;
    logic         n_flag = 1'b0;
    logic         o_flag = 1'b0;
    logic [N-1:0] din;
    logic [M-1:0] waddr;
    logic [M-1:0] ra;
    logic [M-1:0] rb;
    logic [2:0]   op;
    logic         ie;
    logic         write;
    logic         reada;
    logic         readb;
    logic         en;
    logic         oe;
    logic         halted;

    logic [15:0]  imem [0:255];
    logic [5:0]   ctl;

    int tests    = 0;
    int failures = 0;

    // Clock generation
    always #5 clk = ~clk;

    assign instr = imem[iaddr];
    assign ctl   = {ie, write, reada, readb, en, oe};

    control_fsm #(.M(M), .N(N), .P(P)) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef CTRL_STEP_EN
        .step   (step),
`endif
        .iaddr  (iaddr),
        .instr  (instr),
        .z_flag (z_flag),
        .n_flag (n_flag),
        .o_flag (o_flag),
        .din    (din),
        .waddr  (waddr),
        .ra     (ra),
        .rb     (rb),
        .op     (op),
        .ie     (ie),
        .write  (write),
        .reada  (reada),
        .readb  (readb),
        .en     (en),
        .oe     (oe),
        .halted (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Everything quiet: no strobes, no addresses, no data.
    task automatic check_idle(input string tag);
        check({tag, " ctl"}, 32'(ctl), 32'h0);
        check({tag, " bus"}, {din, waddr, ra, rb, op}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'hE000;   // NOP fill
        imem[0]   = 16'h8001;  // LDI r0, 0x01
        imem[1]   = 16'h0200;  // ALU op0 rd1 rs1=0 rs2=0
        imem[2]   = 16'h6770;  // ALU op6 rd3 rs1=5 rs2=6
        imem[3]   = 16'hC002;  // BRA +2 -> 5
        imem[5]   = 16'hA1FE;  // BRZ -2
        imem[6]   = 16'h9080;  // OUT r2
        imem[7]   = 16'hE000;  // NOP
        imem[8]   = 16'hB002;  // BRN +2 (taken) -> 10
        imem[10]  = 16'hB005;  // BRN +5 (not taken) -> 11
        imem[11]  = 16'hD004;  // BRO +4 (taken) -> 15
        imem[15]  = 16'hD004;  // BRO +4 (not taken) -> 16
        imem[16]  = 16'hC0EF;  // BRA +239 -> 255
        imem[255] = 16'hC001;  // BRA +1 -> wraps to 0
        imem[20]  = 16'hF000;  // HALT

        // Reset
        #1 rst = 1'b0;
        cyc();
        check("reset pc", 32'(iaddr), 32'h0);
        check_idle("reset");
        check("reset halted", 32'(halted), 32'h0);
        rst = 1'b1;

        // LDI r0,0x01
        cyc();
        check("ldi ctl", 32'(ctl), 32'b110000);
        check("ldi waddr", 32'(waddr), 32'h0);
        check("ldi din", 32'(din), 32'h01);
        cyc();
        check("ldi pc", 32'(iaddr), 32'h1);
        check_idle("fetch1");
        imem[0] = 16'hC014;    // after the wrap, jump to the HALT at 20

        // ALU 0x0200
        cyc();
        check("alu0 exec ctl", 32'(ctl), 32'b001110);
        check("alu0 exec ra/rb/op", {ra, rb, op}, 32'h0);
        cyc();
        check("alu0 wb ctl", 32'(ctl), 32'b010000);
        check("alu0 wb waddr", 32'(waddr), 32'h1);
        cyc();
        check("alu0 pc", 32'(iaddr), 32'h2);

        // ALU 0x6770
        cyc();
        check("alu6 exec ctl", 32'(ctl), 32'b001110);
        check("alu6 ra", 32'(ra), 32'd5);
        check("alu6 rb", 32'(rb), 32'd6);
        check("alu6 op", 32'(op), 32'd6);
        cyc();
        check("alu6 wb waddr", 32'(waddr), 32'd3);
        check("alu6 wb ctl", 32'(ctl), 32'b010000);
        cyc();
        check("alu6 pc", 32'(iaddr), 32'h3);

        // BRA +2, then BRZ -2 with z raised only during EXEC
        cyc();
        check_idle("bra exec");
        cyc();
        check("bra pc", 32'(iaddr), 32'h5);
        z_flag = 1'b0;
        cyc();
        z_flag = 1'b1;
        cyc();
        check("brz taken pc", 32'(iaddr), 32'h3);
        z_flag = 1'b0;
        cyc();
        cyc();
        check("bra again pc", 32'(iaddr), 32'h5);
        cyc();
        cyc();
        check("brz not taken pc", 32'(iaddr), 32'h6);

        // OUT r2
        cyc();
        check("out ctl", 32'(ctl), 32'b001001);
        check("out ra", 32'(ra), 32'd2);
        cyc();
        check("out pc", 32'(iaddr), 32'h7);
        check("out oe off", 32'(oe), 32'h0);

        // NOP
        cyc();
        check_idle("nop exec");
        cyc();
        check("nop pc", 32'(iaddr), 32'h8);

        // BRN taken, BRN not taken
        cyc();
        n_flag = 1'b1;
        cyc();
        check("brn taken pc", 32'(iaddr), 32'd10);
        n_flag = 1'b0;
        cyc();
        cyc();
        check("brn not taken pc", 32'(iaddr), 32'd11);

        // BRO taken, BRO not taken
        cyc();
        o_flag = 1'b1;
        cyc();
        check("bro taken pc", 32'(iaddr), 32'd15);
        o_flag = 1'b0;
        cyc();
        cyc();
        check("bro not taken pc", 32'(iaddr), 32'd16);

        // Long forward branch to 0xFF, then wrap to 0x00
        cyc();
        cyc();
        check("bra to ff pc", 32'(iaddr), 32'hFF);
        cyc();
        cyc();
        check("bra wrap pc", 32'(iaddr), 32'h00);

        // BRA +20 to the HALT
        cyc();
        cyc();
        check("bra to halt pc", 32'(iaddr), 32'd20);
        cyc();
        check("halt exec halted", 32'(halted), 32'h0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("halt halted", 32'(halted), 32'h1);
            check("halt pc", 32'(iaddr), 32'd20);
            check_idle("halt");
        end

        // Reset out of HALT
        rst = 1'b0;
        #1;
        check("halt rst pc", 32'(iaddr), 32'h0);
        check("halt rst halted", 32'(halted), 32'h0);
        imem[0] = 16'h0200;
        cyc();
        rst = 1'b1;

        // Reset during ALU write-back: write must drop immediately
        cyc();
        check("rst-alu exec ctl", 32'(ctl), 32'b001110);
        cyc();
        check("rst-alu wb write", 32'(write), 32'h1);
        rst = 1'b0;
        #1;
        check("rst-alu write dropped", 32'(write), 32'h0);
        check("rst-alu pc", 32'(iaddr), 32'h0);
        cyc();
        check_idle("rst-alu hold");
        rst = 1'b1;
        cyc();
        check("restart exec ctl", 32'(ctl), 32'b001110);
        check("restart pc", 32'(iaddr), 32'h0);

`ifdef CTRL_STEP_EN
        // Single-step: FETCH holds while step is low
        cyc();
        cyc();
        check("step fetch pc", 32'(iaddr), 32'h1);
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("step hold pc", 32'(iaddr), 32'h1);
            check_idle("step hold");
        end
        step = 1'b1;
        cyc();
        check("step release ctl", 32'(ctl), 32'b001110);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
